// File: rtl/alu_rs_scheduler_pkg.sv
// Shared types, widths and the 16-bit find-first helper for the ALU reservation station.
// Tag value 0 means "operand already holds its value".
package alu_rs_scheduler_pkg;

    localparam int RS_SIZE = 16;
    localparam int OP_W    = 5;
    localparam int DATA_W  = 32;
    localparam int ROB_W   = 5;

    localparam logic [ROB_W-1:0] NO_TAG = {ROB_W{1'b0}};

    typedef enum logic [OP_W-1:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_AND = 5'd2,
        ALU_OR  = 5'd3,
        ALU_XOR = 5'd4,
        ALU_SLL = 5'd5,
        ALU_SRL = 5'd6,
        ALU_SRA = 5'd7,
        ALU_SLT = 5'd8,
        ALU_SLTU = 5'd9
    } alu_op_e;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } ff16_t;

    // Lowest set bit wins; the downward scan lets lower indices overwrite higher ones.
    function automatic ff16_t find_first16(input logic [15:0] vec);
        ff16_t res;
        res.found = 1'b0;
        res.idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            res.found = vec[i] ? 1'b1 : res.found;
            res.idx   = vec[i] ? 4'(i) : res.idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_scheduler_slot.sv
// One reservation-station entry: captures a dispatched op, wakes operands from the CDB,
// and reports when both operands are available.
module alu_rs_scheduler_slot
    import alu_rs_scheduler_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              wr_en,
    input  logic              clr_en,
    input  logic [OP_W-1:0]   wr_op,
    input  logic [DATA_W-1:0] wr_vj,
    input  logic [DATA_W-1:0] wr_vk,
    input  logic [ROB_W-1:0]  wr_qj,
    input  logic [ROB_W-1:0]  wr_qk,
    input  logic [ROB_W-1:0]  wr_dest,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              busy,
    output logic              ready,
    output logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] vj,
    output logic [DATA_W-1:0] vk,
    output logic [ROB_W-1:0]  dest
);

    logic              busy_r;
    logic [OP_W-1:0]   op_r;
    logic [DATA_W-1:0] vj_r, vk_r;
    logic [ROB_W-1:0]  qj_r, qk_r, dest_r;
    logic              byp_j_s, byp_k_s, wake_j_s, wake_k_s;

    // Tag matches for dispatch-time bypass and for wakeup of a resident entry.
    always_comb begin
        byp_j_s  = cdb_valid && (wr_qj != NO_TAG) && (wr_qj == cdb_tag);
        byp_k_s  = cdb_valid && (wr_qk != NO_TAG) && (wr_qk == cdb_tag);
        wake_j_s = cdb_valid && busy_r && (qj_r != NO_TAG) && (qj_r == cdb_tag);
        wake_k_s = cdb_valid && busy_r && (qk_r != NO_TAG) && (qk_r == cdb_tag);
    end

    // Entry state; write and issue-clear never target the same slot in one cycle.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            busy_r <= 1'b0;
            op_r   <= {OP_W{1'b0}};
            vj_r   <= {DATA_W{1'b0}};
            vk_r   <= {DATA_W{1'b0}};
            qj_r   <= NO_TAG;
            qk_r   <= NO_TAG;
            dest_r <= NO_TAG;
        end else if (rdy_in) begin
            if (flush_in) begin
                busy_r <= 1'b0;
            end else if (wr_en) begin
                busy_r <= 1'b1;
                op_r   <= wr_op;
                dest_r <= wr_dest;
                vj_r   <= byp_j_s ? cdb_value : wr_vj;
                qj_r   <= byp_j_s ? NO_TAG : wr_qj;
                vk_r   <= byp_k_s ? cdb_value : wr_vk;
                qk_r   <= byp_k_s ? NO_TAG : wr_qk;
            end else if (clr_en) begin
                busy_r <= 1'b0;
            end else begin
                if (wake_j_s) begin
                    vj_r <= cdb_value;
                    qj_r <= NO_TAG;
                end
                if (wake_k_s) begin
                    vk_r <= cdb_value;
                    qk_r <= NO_TAG;
                end
            end
        end
    end

    assign busy  = busy_r;
    assign ready = busy_r && (qj_r == NO_TAG) && (qk_r == NO_TAG);
    assign op    = op_r;
    assign vj    = vj_r;
    assign vk    = vk_r;
    assign dest  = dest_r;

endmodule

// File: rtl/alu_rs_scheduler.sv
// 16-entry ALU reservation station: lowest-free-slot allocation, CDB wakeup,
// lowest-index ready issue through a registered valid/ready output stage.
module alu_rs_scheduler
    import alu_rs_scheduler_pkg::*;
(
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              rdy_in,
    input  logic              flush_in,
    input  logic              disp_valid,
    output logic              disp_ready,
    input  logic [OP_W-1:0]   disp_op,
    input  logic [DATA_W-1:0] disp_vj,
    input  logic [DATA_W-1:0] disp_vk,
    input  logic [ROB_W-1:0]  disp_qj,
    input  logic [ROB_W-1:0]  disp_qk,
    input  logic [ROB_W-1:0]  disp_dest,
    input  logic              cdb_valid,
    input  logic [ROB_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    output logic              iss_valid,
    input  logic              iss_ready,
    output logic [OP_W-1:0]   iss_op,
    output logic [DATA_W-1:0] iss_a,
    output logic [DATA_W-1:0] iss_b,
    output logic [ROB_W-1:0]  iss_dest,
    output logic [4:0]        occupancy,
    output logic              almost_full
);

    logic [RS_SIZE-1:0] busy_s, ready_s, wr_en_s, clr_en_s;
    logic [OP_W-1:0]    slot_op_s   [RS_SIZE];
    logic [DATA_W-1:0]  slot_vj_s   [RS_SIZE];
    logic [DATA_W-1:0]  slot_vk_s   [RS_SIZE];
    logic [ROB_W-1:0]   slot_dest_s [RS_SIZE];

    ff16_t       vac_s, sel_s;
    logic        active_s, iss_free_s, disp_ready_s, disp_fire_s, issue_fire_s;
    logic [4:0]  occ_next_s;

    logic              iss_valid_r;
    logic [OP_W-1:0]   iss_op_r;
    logic [DATA_W-1:0] iss_a_r, iss_b_r;
    logic [ROB_W-1:0]  iss_dest_r;
    logic [4:0]        occupancy_r;
    logic              almost_full_r;

    for (genvar g = 0; g < RS_SIZE; g++) begin : g_slot
        alu_rs_scheduler_slot u_slot (
            .clk_in    (clk_in),
            .rst_in    (rst_in),
            .rdy_in    (rdy_in),
            .flush_in  (flush_in),
            .wr_en     (wr_en_s[g]),
            .clr_en    (clr_en_s[g]),
            .wr_op     (disp_op),
            .wr_vj     (disp_vj),
            .wr_vk     (disp_vk),
            .wr_qj     (disp_qj),
            .wr_qk     (disp_qk),
            .wr_dest   (disp_dest),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .cdb_value (cdb_value),
            .busy      (busy_s[g]),
            .ready     (ready_s[g]),
            .op        (slot_op_s[g]),
            .vj        (slot_vj_s[g]),
            .vk        (slot_vk_s[g]),
            .dest      (slot_dest_s[g])
        );
    end

    // Slot selection, handshake qualification and next occupancy.
    always_comb begin
        vac_s        = find_first16(~busy_s);
        sel_s        = find_first16(ready_s);
        active_s     = rdy_in && !flush_in;
        disp_ready_s = (occupancy_r < 5'd16);
        iss_free_s   = !iss_valid_r || iss_ready;
        disp_fire_s  = active_s && disp_valid && disp_ready_s && vac_s.found;
        issue_fire_s = active_s && iss_free_s && sel_s.found;
        wr_en_s      = disp_fire_s ? (16'd1 << vac_s.idx) : 16'd0;
        clr_en_s     = issue_fire_s ? (16'd1 << sel_s.idx) : 16'd0;
        case ({disp_fire_s, issue_fire_s})
            2'b10:   occ_next_s = occupancy_r + 5'd1;
            2'b01:   occ_next_s = occupancy_r - 5'd1;
            default: occ_next_s = occupancy_r;
        endcase
    end

    // Issue output register plus occupancy/almost-full bookkeeping.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            iss_valid_r   <= 1'b0;
            iss_op_r      <= {OP_W{1'b0}};
            iss_a_r       <= {DATA_W{1'b0}};
            iss_b_r       <= {DATA_W{1'b0}};
            iss_dest_r    <= NO_TAG;
            occupancy_r   <= 5'd0;
            almost_full_r <= 1'b0;
        end else if (rdy_in) begin
            if (flush_in) begin
                iss_valid_r   <= 1'b0;
                occupancy_r   <= 5'd0;
                almost_full_r <= 1'b0;
            end else begin
                occupancy_r   <= occ_next_s;
                almost_full_r <= (occ_next_s == 5'd15);
                if (iss_free_s) begin
                    iss_valid_r <= sel_s.found;
                    if (sel_s.found) begin
                        iss_op_r   <= slot_op_s[sel_s.idx];
                        iss_a_r    <= slot_vj_s[sel_s.idx];
                        iss_b_r    <= slot_vk_s[sel_s.idx];
                        iss_dest_r <= slot_dest_s[sel_s.idx];
                    end
                end
            end
        end
    end

    assign disp_ready  = disp_ready_s;
    assign iss_valid   = iss_valid_r;
    assign iss_op      = iss_op_r;
    assign iss_a       = iss_a_r;
    assign iss_b       = iss_b_r;
    assign iss_dest    = iss_dest_r;
    assign occupancy   = occupancy_r;
    assign almost_full = almost_full_r;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed bench for alu_rs_scheduler: a vector table for single-op latency and wakeup,
// then hand sequences for fill/drain, stall, flush, rdy_in hold and reset.
module tb_alu_rs_scheduler;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, flush_in;
    logic        disp_valid, disp_ready;
    logic [4:0]  disp_op;
    logic [31:0] disp_vj, disp_vk;
    logic [4:0]  disp_qj, disp_qk, disp_dest;
    logic        cdb_valid;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value;
    logic        iss_valid, iss_ready;
    logic [4:0]  iss_op;
    logic [31:0] iss_a, iss_b;
    logic [4:0]  iss_dest;
    logic [4:0]  occupancy;
    logic        almost_full;

    int errors = 0;
    int checks = 0;

    alu_rs_scheduler dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_dest(disp_dest), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
        .cdb_value(cdb_value), .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_dest(iss_dest),
        .occupancy(occupancy), .almost_full(almost_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rst, dv;
        logic [4:0]  op;
        logic [31:0] vj, vk;
        logic [4:0]  qj, qk, dest;
        logic        cv;
        logic [4:0]  ctag;
        logic [31:0] cval;
        logic        e_iv, chk_data;
        logic [4:0]  e_op;
        logic [31:0] e_a, e_b;
        logic [4:0]  e_dest, e_occ;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic rst, logic dv, logic [4:0] op, logic [31:0] vj,
                                logic [31:0] vk, logic [4:0] qj, logic [4:0] qk,
                                logic [4:0] dest, logic cv, logic [4:0] ctag,
                                logic [31:0] cval, logic e_iv, logic chk_data,
                                logic [4:0] e_op, logic [31:0] e_a, logic [31:0] e_b,
                                logic [4:0] e_dest, logic [4:0] e_occ);
        vec_t v;
        v.rst = rst; v.dv = dv; v.op = op; v.vj = vj; v.vk = vk; v.qj = qj; v.qk = qk;
        v.dest = dest; v.cv = cv; v.ctag = ctag; v.cval = cval; v.e_iv = e_iv;
        v.chk_data = chk_data; v.e_op = e_op; v.e_a = e_a; v.e_b = e_b;
        v.e_dest = e_dest; v.e_occ = e_occ;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle();
        rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; disp_valid = 1'b0;
        disp_op = 5'd0; disp_vj = 32'd0; disp_vk = 32'd0; disp_qj = 5'd0;
        disp_qk = 5'd0; disp_dest = 5'd0; cdb_valid = 1'b0; cdb_tag = 5'd0;
        cdb_value = 32'd0; iss_ready = 1'b1;
    endtask

    initial begin
        idle();
        rst_in = 1'b1;

        // rst dv op vj vk qj qk dest | cv ctag cval | iv chk op a b dest occ
        vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        0, 1, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 3, 5, 7, 0, 0, 4,  0, 0, 0,        0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 1, 3, 5, 7, 4, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, 1, 1, 0, 1, 9, 0, 6,  0, 0, 0,        0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 9, 32'h11,   0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 1, 1, 32'h11, 1, 6, 0));
        vq.push_back(mk(0, 1, 2, 0, 2, 9, 0, 7,  1, 9, 32'h11,   0, 0, 0, 0, 0, 0, 1));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        1, 1, 2, 32'h11, 2, 7, 0));
        vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0,        0, 0, 0, 0, 0, 0, 0));

        for (int i = 0; i < vq.size(); i++) begin
            rst_in = vq[i].rst; disp_valid = vq[i].dv; disp_op = vq[i].op;
            disp_vj = vq[i].vj; disp_vk = vq[i].vk; disp_qj = vq[i].qj;
            disp_qk = vq[i].qk; disp_dest = vq[i].dest; cdb_valid = vq[i].cv;
            cdb_tag = vq[i].ctag; cdb_value = vq[i].cval;
            tick();
            chk($sformatf("vec%0d.iss_valid", i), 32'(iss_valid), 32'(vq[i].e_iv));
            chk($sformatf("vec%0d.occupancy", i), 32'(occupancy), 32'(vq[i].e_occ));
            chk($sformatf("vec%0d.disp_ready", i), 32'(disp_ready), 32'd1);
            chk($sformatf("vec%0d.almost_full", i), 32'(almost_full), 32'd0);
            if (vq[i].chk_data) begin
                chk($sformatf("vec%0d.iss_op", i), 32'(iss_op), 32'(vq[i].e_op));
                chk($sformatf("vec%0d.iss_a", i), iss_a, vq[i].e_a);
                chk($sformatf("vec%0d.iss_b", i), iss_b, vq[i].e_b);
                chk($sformatf("vec%0d.iss_dest", i), 32'(iss_dest), 32'(vq[i].e_dest));
            end
        end

        // Fill all 16 slots with ops waiting on tag 2 in their second operand.
        idle();
        disp_valid = 1'b1; disp_qk = 5'd2;
        for (int i = 0; i < 16; i++) begin
            disp_op = 5'(i); disp_vj = 32'(i); disp_vk = 32'(100 + i); disp_dest = 5'(i + 1);
            tick();
            chk($sformatf("fill%0d.occupancy", i), 32'(occupancy), 32'(i + 1));
            chk($sformatf("fill%0d.almost_full", i), 32'(almost_full), 32'(i == 14));
            chk($sformatf("fill%0d.disp_ready", i), 32'(disp_ready), 32'(i < 15));
        end
        disp_dest = 5'd31;
        tick();
        chk("full_extra.occupancy", 32'(occupancy), 32'd16);
        chk("full_extra.disp_ready", 32'(disp_ready), 32'd0);
        chk("full_extra.iss_valid", 32'(iss_valid), 32'd0);
        disp_valid = 1'b0;
        cdb_valid = 1'b1; cdb_tag = 5'd2; cdb_value = 32'hC0DE;
        tick();
        cdb_valid = 1'b0;
        chk("wake_all.iss_valid", 32'(iss_valid), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            chk($sformatf("drain%0d.iss_valid", k), 32'(iss_valid), 32'd1);
            chk($sformatf("drain%0d.iss_a", k), iss_a, 32'(k));
            chk($sformatf("drain%0d.iss_b", k), iss_b, 32'hC0DE);
            chk($sformatf("drain%0d.iss_dest", k), 32'(iss_dest), 32'(k + 1));
            chk($sformatf("drain%0d.occupancy", k), 32'(occupancy), 32'(15 - k));
            chk($sformatf("drain%0d.almost_full", k), 32'(almost_full), 32'(k == 0));
        end
        tick();
        chk("drained.iss_valid", 32'(iss_valid), 32'd0);

        // Stall with two ready entries, then release.
        idle();
        iss_ready = 1'b0; disp_valid = 1'b1;
        disp_vj = 32'hA1; disp_vk = 32'hA2; disp_dest = 5'd3;
        tick();
        disp_vj = 32'hB1; disp_vk = 32'hB2; disp_dest = 5'd5;
        tick();
        disp_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("stall%0d.iss_valid", c), 32'(iss_valid), 32'd1);
            chk($sformatf("stall%0d.iss_a", c), iss_a, 32'hA1);
            chk($sformatf("stall%0d.iss_b", c), iss_b, 32'hA2);
            chk($sformatf("stall%0d.iss_dest", c), 32'(iss_dest), 32'd3);
            chk($sformatf("stall%0d.occupancy", c), 32'(occupancy), 32'd1);
        end
        iss_ready = 1'b1;
        tick();
        chk("release.iss_valid", 32'(iss_valid), 32'd1);
        chk("release.iss_a", iss_a, 32'hB1);
        chk("release.iss_dest", 32'(iss_dest), 32'd5);
        chk("release.occupancy", 32'(occupancy), 32'd0);
        tick();
        chk("release_done.iss_valid", 32'(iss_valid), 32'd0);

        // Flush while stalled with six busy entries; same-cycle dispatch must be dropped.
        idle();
        iss_ready = 1'b0; disp_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            disp_vj = 32'h200 + 32'(i); disp_dest = 5'(i + 1);
            tick();
        end
        chk("pre_flush.occupancy", 32'(occupancy), 32'd6);
        chk("pre_flush.iss_a", iss_a, 32'h200);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0; disp_valid = 1'b0;
        chk("flush.iss_valid", 32'(iss_valid), 32'd0);
        chk("flush.occupancy", 32'(occupancy), 32'd0);
        chk("flush.disp_ready", 32'(disp_ready), 32'd1);
        chk("flush.almost_full", 32'(almost_full), 32'd0);
        iss_ready = 1'b1;
        tick();
        chk("post_flush.iss_valid", 32'(iss_valid), 32'd0);
        chk("post_flush.occupancy", 32'(occupancy), 32'd0);

        // rdy_in low freezes state against CDB and dispatch activity.
        idle();
        disp_valid = 1'b1; disp_op = 5'd4; disp_vj = 32'h44; disp_qj = 5'd12; disp_dest = 5'd10;
        tick();
        chk("hold_setup.occupancy", 32'(occupancy), 32'd1);
        rdy_in = 1'b0; cdb_valid = 1'b1; cdb_tag = 5'd12; cdb_value = 32'h66;
        disp_qj = 5'd0; disp_dest = 5'd11;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk($sformatf("hold%0d.occupancy", c), 32'(occupancy), 32'd1);
            chk($sformatf("hold%0d.iss_valid", c), 32'(iss_valid), 32'd0);
            chk($sformatf("hold%0d.disp_ready", c), 32'(disp_ready), 32'd1);
        end
        rdy_in = 1'b1; cdb_valid = 1'b0; disp_valid = 1'b0;
        tick();
        chk("unhold.iss_valid", 32'(iss_valid), 32'd0);
        chk("unhold.occupancy", 32'(occupancy), 32'd1);
        cdb_valid = 1'b1;
        tick();
        cdb_valid = 1'b0;
        chk("late_wake.iss_valid", 32'(iss_valid), 32'd0);
        tick();
        chk("late_issue.iss_valid", 32'(iss_valid), 32'd1);
        chk("late_issue.iss_a", iss_a, 32'h66);
        chk("late_issue.iss_dest", 32'(iss_dest), 32'd10);
        iss_ready = 1'b0; disp_valid = 1'b1; disp_qj = 5'd13; disp_dest = 5'd12;
        tick();
        disp_valid = 1'b0;
        chk("pre_rst.occupancy", 32'(occupancy), 32'd1);
        chk("pre_rst.iss_valid", 32'(iss_valid), 32'd1);
        rdy_in = 1'b0; rst_in = 1'b1;
        tick();
        rst_in = 1'b0; rdy_in = 1'b1;
        chk("rst_hold.iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_hold.iss_op", 32'(iss_op), 32'd0);
        chk("rst_hold.iss_a", iss_a, 32'd0);
        chk("rst_hold.iss_b", iss_b, 32'd0);
        chk("rst_hold.iss_dest", 32'(iss_dest), 32'd0);
        chk("rst_hold.occupancy", 32'(occupancy), 32'd0);
        chk("rst_hold.disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_hold.almost_full", 32'(almost_full), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
